// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD accumulator / multiplexed display.
// Contents:
//   state_t   - accumulator control states (IDLE, ADD)
//   bcd_t     - one 4-bit BCD digit
//   SEG_0..9  - segment patterns {a,b,c,d,e,f,g}, a at MSB, active-high
//   SEG_BLANK - all segments off
package bcd_disp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder.
// Ports:
//   digit - 4-bit input code
//   seg   - segments {a,b,c,d,e,f,g}, active-high; codes 10..15 give all off
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_accum_display.sv
// BCD accumulator with a time-multiplexed seven-segment display.
// An accepted operand is added into the DIGITS-digit BCD accumulator one
// digit per cycle (digit 0 first); the display scanner independently cycles
// through the digits, holding each for SCAN_DIV clocks.
// Ports:
//   clk       - clock, all state on rising edge
//   rst_n     - synchronous active-low reset
//   clear     - synchronous clear of accumulator and overflow (beats add)
//   add_valid - operand offered
//   add_data  - BCD operand 0..9 (10..15 is flagged via err)
//   add_ready - operand can be accepted this cycle
//   err       - one-cycle pulse after an illegal operand is accepted
//   overflow  - sticky carry-out of the top digit
//   seg       - segments {a..g}, active-high, registered
//   digit_sel - one-hot digit enable, bit 0 = least-significant digit
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_accum_display
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              add_valid,
  input  logic [3:0]        add_data,
  output logic              add_ready,
  output logic              err,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE   = PW'(SCAN_DIV - 1);

  // ---------------- accumulator control ----------------
  state_t            state_reg, state_next;
  bcd_t [DIGITS-1:0] acc_reg, acc_next;
  bcd_t              operand_reg, operand_next;
  logic              carry_reg, carry_next;
  logic [IW-1:0]     k_reg, k_next;
  logic              overflow_reg, overflow_next;
  logic              err_reg, err_next;
  logic              accept;
  bcd_t              cur_digit;
  logic [4:0]        t_sum;

  // rst_n is folded in so the block never looks ready while held in reset.
  assign add_ready = rst_n && (state_reg == ST_IDLE) && !clear;
  assign accept    = add_valid && add_ready;

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    operand_next  = operand_reg;
    carry_next    = carry_reg;
    k_next        = k_reg;
    overflow_next = overflow_reg;
    err_next      = 1'b0;
    cur_digit     = acc_reg[k_reg];
    // Operand only enters at digit 0; carry is always 0 there.
    t_sum = {1'b0, cur_digit} + {4'b0000, carry_reg} +
            ((k_reg == '0) ? {1'b0, operand_reg} : 5'd0);

    if (clear) begin
      state_next    = ST_IDLE;
      acc_next      = '0;
      overflow_next = 1'b0;
      carry_next    = 1'b0;
      k_next        = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (add_data > 4'd9) begin
              err_next = 1'b1;
            end else begin
              operand_next = add_data;
              carry_next   = 1'b0;
              k_next       = '0;
              state_next   = ST_ADD;
            end
          end
        end
        ST_ADD: begin
          if (t_sum > 5'd9) begin
            acc_next[k_reg] = 4'(t_sum - 5'd10);
            carry_next      = 1'b1;
          end else begin
            acc_next[k_reg] = t_sum[3:0];
            carry_next      = 1'b0;
          end
          if (k_reg == LAST_DIGIT) begin
            state_next = ST_IDLE;
            k_next     = '0;
            if (t_sum > 5'd9) overflow_next = 1'b1;
          end else begin
            k_next = k_reg + IW'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      operand_reg  <= '0;
      carry_reg    <= 1'b0;
      k_reg        <= '0;
      overflow_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      operand_reg  <= operand_next;
      carry_reg    <= carry_next;
      k_reg        <= k_next;
      overflow_reg <= overflow_next;
      err_reg      <= err_next;
    end
  end

  assign overflow = overflow_reg;
  assign err      = err_reg;

  // ---------------- display scanner ----------------
  logic [PW-1:0]     pre_reg, pre_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [6:0]        seg_reg, seg_dec;
  logic [DIGITS-1:0] digit_sel_reg;
  logic [DIGITS-1:0] blank_mask;

  always_comb begin
    pre_next = pre_reg + PW'(1);
    idx_next = idx_reg;
    if (pre_reg == LAST_PRE) begin
      pre_next = '0;
      idx_next = (idx_reg == LAST_DIGIT) ? '0 : idx_reg + IW'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; the chain
  // runs from the top digit down. Digit 0 always shows.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_lsd
      assign blank_mask[gi] = 1'b0;
    end else if (gi == DIGITS - 1) begin : g_msd
      assign blank_mask[gi] = (acc_reg[gi] == 4'd0);
    end else begin : g_mid
      assign blank_mask[gi] = (acc_reg[gi] == 4'd0) && blank_mask[gi+1];
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Decode the digit that will be selected after this edge, so seg and
  // digit_sel update together.
  seg7_decode u_seg7_decode (
    .digit (acc_reg[idx_next]),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_reg       <= '0;
      idx_reg       <= '0;
      seg_reg       <= SEG_0;
      digit_sel_reg <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else begin
      pre_reg       <= pre_next;
      idx_reg       <= idx_next;
      seg_reg       <= blank_mask[idx_next] ? SEG_BLANK : seg_dec;
      digit_sel_reg <= {{(DIGITS-1){1'b0}}, 1'b1} << idx_next;
    end
  end

  assign seg       = seg_reg;
  assign digit_sel = digit_sel_reg;

endmodule

// File: tb/tb_bcd_accum_display.sv
// Self-checking bench for bcd_accum_display (DIGITS=4, SCAN_DIV=4).
// Expected accumulator values are pushed to a queue at each add and popped
// when the scanned display is captured and compared digit by digit.
module tb_bcd_accum_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              add_valid;
  logic [3:0]        add_data;
  logic              add_ready;
  logic              err;
  logic              overflow;
  logic [6:0]        seg;
  logic [DIGITS-1:0] digit_sel;

  always #5 clk = ~clk;

  bcd_accum_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .add_valid (add_valid),
    .add_data  (add_data),
    .add_ready (add_ready),
    .err       (err),
    .overflow  (overflow),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int model_acc = 0;
  bit model_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && v < p) return 7'b0000000;
`endif
    return ref_seg((v / p) % 10);
  endfunction

  task automatic do_add(input int d, input bit track);
    int n;
    n = 0;
    while (!add_ready && n < 50) begin tick(); n++; end
    check_val("ready_wait", {31'b0, n < 50}, 32'd1);
    add_valid = 1'b1;
    add_data  = d[3:0];
    tick();
    add_valid = 1'b0;
    if (d > 9) begin
      check_val("err_pulse", {31'b0, err}, 32'd1);
      check_val("ready_after_err", {31'b0, add_ready}, 32'd1);
      tick();
      check_val("err_drop", {31'b0, err}, 32'd0);
      n = 0;
    end else begin
      model_acc = model_acc + d;
      if (model_acc >= 10 ** DIGITS) begin
        model_acc = model_acc - 10 ** DIGITS;
        model_ovf = 1'b1;
      end
      n = 0;
      while (!add_ready && n < 50) begin tick(); n++; end
      check_val("busy_cycles", n, DIGITS);
    end
    check_val("overflow", {31'b0, overflow}, {31'b0, model_ovf});
    if (track) begin
      exp_q.push_back(model_acc);
      $display("ADD data=%0d model_acc=%0d ovf=%0d busy=%0d", d, model_acc, model_ovf, n);
    end
  endtask

  task automatic check_display();
    int         exp_v;
    int         idx;
    int         seen;
    int         n;
    logic [6:0] cap [DIGITS];
    bit         got [DIGITS];
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    exp_v = exp_q.pop_front();
    for (int i = 0; i < DIGITS; i++) begin cap[i] = 'x; got[i] = 1'b0; end
    tick();
    tick();
    seen = 0;
    n    = 0;
    while (seen < DIGITS && n < 4 * DIGITS * SCAN_DIV) begin
      idx = -1;
      for (int i = 0; i < DIGITS; i++) if (digit_sel == (1 << i)) idx = i;
      if (idx < 0) check_val("digit_sel_onehot", $countones(digit_sel), 32'd1);
      else if (!got[idx]) begin
        got[idx] = 1'b1;
        cap[idx] = seg;
        seen++;
      end
      tick();
      n++;
    end
    for (int i = 0; i < DIGITS; i++)
      check_val($sformatf("seg_d%0d", i), {25'b0, cap[i]}, {25'b0, exp_seg(exp_v, i)});
    $display("DISPLAY expected=%0d d3..d0=%b %b %b %b", exp_v, cap[3], cap[2], cap[1], cap[0]);
  endtask

  task automatic check_scan();
    logic [DIGITS-1:0] prev;
    int run;
    int n;
    prev = digit_sel;
    n = 0;
    while (digit_sel == prev && n < 20) begin tick(); n++; end
    check_val("scan_align", {31'b0, n < 20}, 32'd1);
    for (int c = 0; c < DIGITS + 1; c++) begin
      prev = digit_sel;
      run  = 0;
      while (digit_sel == prev && run < 20) begin tick(); run++; end
      check_val("scan_hold", run, SCAN_DIV);
      check_val("scan_next", {28'b0, digit_sel},
                (prev == (1 << (DIGITS - 1))) ? 32'd1 : {27'b0, prev, 1'b0});
      $display("SCAN from=%b to=%b held=%0d", prev, digit_sel, run);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    add_valid = 1'b0;
    add_data  = 4'd0;
    tick();
    tick();
    tick();
    check_val("ready_in_reset", {31'b0, add_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rst_ready", {31'b0, add_ready}, 32'd1);
    check_val("rst_digit_sel", {28'b0, digit_sel}, 32'd1);
    check_val("rst_seg", {25'b0, seg}, 32'b1111110);
    check_val("rst_overflow", {31'b0, overflow}, 32'd0);
    check_val("rst_err", {31'b0, err}, 32'd0);

    check_scan();

    do_add(7, 1'b1);
    check_display();
    do_add(5, 1'b1);
    check_display();
    check_scan();

    do_add(12, 1'b1);
    check_display();
    do_add(9, 1'b1);
    check_display();

    // clear in the second ADD cycle, with a simultaneous add_valid
    add_valid = 1'b1;
    add_data  = 4'd3;
    tick();
    add_valid = 1'b0;
    tick();
    clear     = 1'b1;
    add_valid = 1'b1;
    #1;
    check_val("ready_during_clear", {31'b0, add_ready}, 32'd0);
    tick();
    clear     = 1'b0;
    add_valid = 1'b0;
    #1;
    check_val("ready_after_clear", {31'b0, add_ready}, 32'd1);
    check_val("ovf_after_clear", {31'b0, overflow}, 32'd0);
    model_acc = 0;
    exp_q.push_back(0);
    $display("CLEAR mid-add model_acc=0");
    check_display();

    // fill to 9999, then wrap
    for (int i = 0; i < 1111; i++) do_add(9, 1'b0);
    exp_q.push_back(model_acc);
    check_display();
    do_add(1, 1'b1);
    check_display();
    do_add(1, 1'b1);
    check_display();

    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    check_val("ovf_cleared", {31'b0, overflow}, 32'd0);
    model_acc = 0;
    model_ovf = 1'b0;
    exp_q.push_back(0);
    $display("CLEAR model_acc=0 ovf=0");
    check_display();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_accum_display.md
BCD_ACCUM_DISPLAY -- requirements
Module: bcd_accum_display

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits in the accumulator and display, range 2..8.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles each digit is displayed, range 2 or more.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clear  input  1  synchronous clear of accumulator and overflow flag.
REQ-006 add_valid  input  1  operand offered this cycle.
REQ-007 add_data  input  4  BCD operand, legal 0..9.
REQ-008 add_ready  output  1  block can accept an operand this cycle.
REQ-009 err  output  1  one-cycle pulse when an illegal operand is accepted.
REQ-010 overflow  output  1  sticky; set when a sum carries out of the top digit.
REQ-011 seg  output  7  segments {a,b,c,d,e,f,g}, a at MSB, active-high.
REQ-012 digit_sel  output  DIGITS  one-hot active-high digit enable; bit 0 is the least-significant digit.

Function
REQ-013 States: IDLE and ADD; add_ready is 1 only when the state is IDLE and clear is 0.
REQ-014 Transfer: add_valid and add_ready both 1 at a rising edge; add_data is latched and the state moves to ADD.
REQ-015 ADD processes one digit per cycle, digit 0 first; digit k is written at the (k+1)th edge after transfer.
REQ-016 Digit rule: t = acc[k] + carry_in (+ operand for k=0 only); if t > 9, the digit becomes t-10 and carry is 1; otherwise the digit becomes t and carry is 0.
REQ-017 After DIGITS cycles in ADD, the state returns to IDLE; add_ready is high again DIGITS+1 cycles after the transfer cycle.
REQ-018 Wrap-around: carry out of digit DIGITS-1 sets overflow, and the accumulator keeps the wrapped value (9..9 + 1 gives 0..0).
REQ-019 Illegal operand (add_data > 9) accepted in IDLE: err is 1 for exactly the next cycle, the accumulator is unchanged, and the state stays IDLE.
REQ-020 clear has highest priority:
- Next edge: accumulator all zeros, overflow 0, state IDLE, any ADD in progress aborted.
- A simultaneous add_valid is not accepted.
REQ-021 overflow clears only on clear or reset; a further overflow while it is set has no additional effect.
REQ-022 Scan: the prescaler counts 0..SCAN_DIV-1; at its wrap, the digit index advances modulo DIGITS.
REQ-023 digit_sel is the one-hot of the digit index.
REQ-024 seg is the registered decode of acc[index], so seg and digit_sel change on the same edge.
REQ-025 Decode table (abcdefg):
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- codes 10..15 give 0000000.
REQ-026 The scan runs independently of ADD and clear; mid-ADD values may be displayed.

Reset
REQ-027 With rst_n = 0 at an edge:
- State IDLE, accumulator all zeros.
- overflow 0, err 0.
- Prescaler 0, digit index 0.
- digit_sel = 1 (bit 0), seg = 1111110.
REQ-028 add_ready is 0 while rst_n is 0 and is 1 in the first cycle after reset release.
REQ-029 Reset overrides clear and aborts any ADD in progress.

Configuration
REQ-030 Macro LEADING_ZERO_BLANK_EN.
- Defined: digits above the most-significant nonzero digit show seg = 0000000; digit 0 is never blanked.
- Undefined: all digits always show their decoded value.

Structure
REQ-031 Package bcd_disp_pkg holds:
- the state enum;
- the ten segment-pattern constants;
- the blank pattern constant;
- the BCD digit typedef (4 bits).
REQ-032 Sub-module seg7_decode: combinational 4-bit to 7-bit decoder per REQ-025, instantiated once on the scan path.

Verification
REQ-033 Reset release -> add_ready=1, digit_sel=0001, seg=1111110, overflow=0.
REQ-034 Add 7, then 5 (DIGITS=4) -> accumulator 0012; add_ready low for 4 cycles after each transfer.
REQ-035 DIGITS=2, accumulator 99, add 1 -> accumulator 00, overflow=1; a following clear -> overflow=0.
REQ-036 clear asserted in the second ADD cycle -> next cycle: accumulator 0000, state IDLE, add_ready=1 once clear is low.
REQ-037 add_data=12 -> err high for one cycle, accumulator unchanged, add_ready high on the next cycle.
REQ-038 SCAN_DIV=4, accumulator 0012 -> digit_sel 0001, 0010, 0100, 1000, each held 4 cycles; seg for digit 0 = 1101101.
- With LEADING_ZERO_BLANK_EN: digits 3 and 2 show 0000000.
